// File: rtl/call_request_if.sv
// Button, mask, clear and request-status bundle between the raw call panels,
// the call request register and the elevator control FSM.
interface call_request_if #(
  parameter int FLOORS = 8
);
  localparam int CNT_W = $clog2(3*FLOORS-1) + 1;

  logic [FLOORS-1:0] btn_in;
  logic [FLOORS-2:0] btn_up_out;
  logic [FLOORS-1:1] btn_down_out;
  logic [FLOORS-1:0] blocked_mask;
  logic              service_mode;
  logic [FLOORS-1:0] inactivate_in_levels;
  logic [FLOORS-2:0] inactivate_out_up_levels;
  logic [FLOORS-1:1] inactivate_out_down_levels;
  logic [FLOORS-1:0] active_in_levels;
  logic [FLOORS-2:0] active_out_up_levels;
  logic [FLOORS-1:1] active_out_down_levels;
  logic [CNT_W-1:0]  pending_count;
  logic              new_request;

  modport slave (
    input  btn_in, btn_up_out, btn_down_out, blocked_mask, service_mode,
           inactivate_in_levels, inactivate_out_up_levels, inactivate_out_down_levels,
    output active_in_levels, active_out_up_levels, active_out_down_levels,
           pending_count, new_request
  );

  modport master (
    output btn_in, btn_up_out, btn_down_out, blocked_mask, service_mode,
           inactivate_in_levels, inactivate_out_up_levels, inactivate_out_down_levels,
    input  active_in_levels, active_out_up_levels, active_out_down_levels,
           pending_count, new_request
  );
endinterface

// File: rtl/call_request_reg.sv
// Elevator call register: synchronises and debounces cabin/hall buttons,
// latches one-shot requests and reports a pending count and new-request strobe.
module call_request_reg #(
  parameter int FLOORS   = 8,
  parameter int DEBOUNCE = 2
) (
  input  logic          clk,
  input  logic          reset,
  call_request_if.slave bus
);
  localparam int NCH   = 3*FLOORS - 2;
  localparam int CNT_W = $clog2(3*FLOORS-1) + 1;
  localparam int DB_W  = $clog2(DEBOUNCE+1);
  localparam logic [DB_W-1:0] DB_MAX  = DB_W'(DEBOUNCE);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE-1);

  // Channel order: cabin 0..F-1, hall-up 0..F-2, hall-down 1..F-1.
  logic [NCH-1:0] raw_ch, clr_ch, blk_ch, hall_ch;

  logic [NCH-1:0]           sync_meta_q, sync_meta_d;
  logic [NCH-1:0]           sync_q, sync_d;
  logic [NCH-1:0][DB_W-1:0] cnt_q, cnt_d;
  logic [NCH-1:0]           armed_q, armed_d;
  logic [NCH-1:0]           active_q, active_d;
  logic                     svc_hist_q, svc_hist_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic                     new_request_q, new_request_d;

  logic [NCH-1:0] qualify;
  logic           svc_rise;

  always_comb begin
    raw_ch  = '0;
    clr_ch  = '0;
    blk_ch  = '0;
    hall_ch = '0;
    for (int f = 0; f < FLOORS; f++) begin
      raw_ch[f] = bus.btn_in[f];
      clr_ch[f] = bus.inactivate_in_levels[f];
      blk_ch[f] = bus.blocked_mask[f];
    end
    for (int f = 0; f < FLOORS-1; f++) begin
      raw_ch[FLOORS+f]  = bus.btn_up_out[f];
      clr_ch[FLOORS+f]  = bus.inactivate_out_up_levels[f];
      blk_ch[FLOORS+f]  = bus.blocked_mask[f];
      hall_ch[FLOORS+f] = 1'b1;
    end
    for (int f = 1; f < FLOORS; f++) begin
      raw_ch[2*FLOORS-2+f]  = bus.btn_down_out[f];
      clr_ch[2*FLOORS-2+f]  = bus.inactivate_out_down_levels[f];
      blk_ch[2*FLOORS-2+f]  = bus.blocked_mask[f];
      hall_ch[2*FLOORS-2+f] = 1'b1;
    end
  end

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    sync_meta_d = raw_ch;
    sync_d      = sync_meta_q;
    cnt_d       = cnt_q;
    armed_d     = armed_q;
    qualify     = '0;
    for (int i = 0; i < NCH; i++) begin
      if (!sync_q[i]) begin
        cnt_d[i]   = '0;
        armed_d[i] = 1'b1;
      end else begin
        if (cnt_q[i] != DB_MAX) cnt_d[i] = cnt_q[i] + DB_W'(1);
        if (armed_q[i] && cnt_q[i] == DB_LAST) begin
          qualify[i] = 1'b1;
          armed_d[i] = 1'b0;
        end
      end
    end
  end

  // Clear always wins over a simultaneous qualifying press.
  always_comb begin
    svc_rise   = bus.service_mode & ~svc_hist_q;
    svc_hist_d = bus.service_mode;
    active_d   = (active_q & ~clr_ch & ~(hall_ch & {NCH{svc_rise}}))
               | (qualify & ~blk_ch & ~clr_ch & ~(hall_ch & {NCH{bus.service_mode}}));
    count_d    = '0;
    for (int i = 0; i < NCH; i++) count_d = count_d + CNT_W'(active_d[i]);
    new_request_d = |(active_d & ~active_q);
  end

  // NOTE: sequential state uses non-blocking assignments; all per-channel state resets with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_meta_q   <= '0;
      sync_q        <= '0;
      cnt_q         <= '0;
      armed_q       <= '1;
      active_q      <= '0;
      svc_hist_q    <= 1'b0;
      count_q       <= '0;
      new_request_q <= 1'b0;
    end else begin
      sync_meta_q   <= sync_meta_d;
      sync_q        <= sync_d;
      cnt_q         <= cnt_d;
      armed_q       <= armed_d;
      active_q      <= active_d;
      svc_hist_q    <= svc_hist_d;
      count_q       <= count_d;
      new_request_q <= new_request_d;
    end
  end

  assign bus.active_in_levels       = active_q[FLOORS-1:0];
  assign bus.active_out_up_levels   = active_q[2*FLOORS-2:FLOORS];
  assign bus.active_out_down_levels = active_q[3*FLOORS-3:2*FLOORS-1];
  assign bus.pending_count          = count_q;
  assign bus.new_request            = new_request_q;
endmodule

// File: tb/tb_call_request_reg.sv
// Directed bench for call_request_reg (8 floors, debounce 2) with hand-computed
// expectations for latency, glitching, re-arm, blocking, service mode and saturation.
module tb_call_request_reg;
  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  call_request_if #(.FLOORS(8)) bus ();

  call_request_reg #(.FLOORS(8), .DEBOUNCE(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_state(input string tag, input logic [7:0] e_in, input logic [6:0] e_up,
                             input logic [6:0] e_dn, input logic [5:0] e_cnt, input logic e_nr);
    check({tag, "_in"},  32'(bus.active_in_levels),       32'(e_in));
    check({tag, "_up"},  32'(bus.active_out_up_levels),   32'(e_up));
    check({tag, "_dn"},  32'(bus.active_out_down_levels), 32'(e_dn));
    check({tag, "_cnt"}, 32'(bus.pending_count),          32'(e_cnt));
    check({tag, "_nr"},  32'(bus.new_request),            32'(e_nr));
  endtask

  initial begin
    bus.btn_in                     = '0;
    bus.btn_up_out                 = '0;
    bus.btn_down_out               = '0;
    bus.blocked_mask               = '0;
    bus.service_mode               = 1'b0;
    bus.inactivate_in_levels       = '0;
    bus.inactivate_out_up_levels   = '0;
    bus.inactivate_out_down_levels = '0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #1 check_state("reset", 8'h00, 7'h00, 7'h00, 6'd0, 1'b0);
    tick(2);
    reset = 1'b1;

    // Single cabin press: visible exactly 3 edges after first sample.
    bus.btn_in = 8'h08;
    tick(3);
    check_state("press_early", 8'h00, 7'h00, 7'h00, 6'd0, 1'b0);
    tick(1);
    check_state("press_set", 8'h08, 7'h00, 7'h00, 6'd1, 1'b1);
    tick(1);
    check("press_pulse_end", 32'(bus.new_request), 32'(0));
    bus.btn_in = 8'h00;
    tick(3);
    check_state("press_hold", 8'h08, 7'h00, 7'h00, 6'd1, 1'b0);
    bus.inactivate_in_levels = 8'h08;
    tick(1);
    bus.inactivate_in_levels = 8'h00;
    check_state("clear", 8'h00, 7'h00, 7'h00, 6'd0, 1'b0);

    // One-cycle raw pulse on a hall button never latches.
    bus.btn_up_out = 7'h04;
    tick(1);
    bus.btn_up_out = 7'h00;
    tick(6);
    check_state("glitch", 8'h00, 7'h00, 7'h00, 6'd0, 1'b0);

    // Held button cleared while held stays clear until released and pressed again.
    bus.btn_in = 8'h20;
    tick(4);
    check_state("hold_set", 8'h20, 7'h00, 7'h00, 6'd1, 1'b1);
    bus.inactivate_in_levels = 8'h20;
    tick(1);
    bus.inactivate_in_levels = 8'h00;
    check("hold_clear_in", 32'(bus.active_in_levels), 32'(0));
    tick(4);
    check_state("hold_stays", 8'h00, 7'h00, 7'h00, 6'd0, 1'b0);
    bus.btn_in = 8'h00;
    tick(3);
    bus.btn_in = 8'h20;
    tick(3);
    check("rearm_early_in", 32'(bus.active_in_levels), 32'(0));
    tick(1);
    check_state("rearm_set", 8'h20, 7'h00, 7'h00, 6'd1, 1'b1);
    tick(1);
    check("rearm_pulse_end", 32'(bus.new_request), 32'(0));
    bus.btn_in = 8'h00;
    bus.inactivate_in_levels = 8'h20;
    tick(1);
    bus.inactivate_in_levels = 8'h00;

    // Blocked floor drops presses, which stay consumed after unblocking.
    bus.blocked_mask = 8'h04;
    bus.btn_in       = 8'h04;
    bus.btn_down_out = 7'h02;
    tick(5);
    check_state("blocked", 8'h00, 7'h00, 7'h00, 6'd0, 1'b0);
    bus.blocked_mask = 8'h00;
    tick(3);
    check_state("blocked_disarmed", 8'h00, 7'h00, 7'h00, 6'd0, 1'b0);
    bus.btn_in       = 8'h00;
    bus.btn_down_out = 7'h00;
    tick(3);
    bus.blocked_mask = 8'h04;
    bus.btn_in       = 8'h02;
    tick(4);
    check_state("unblocked_floor", 8'h02, 7'h00, 7'h00, 6'd1, 1'b1);
    bus.btn_in       = 8'h00;
    bus.blocked_mask = 8'h02;
    tick(2);
    check_state("block_keeps", 8'h02, 7'h00, 7'h00, 6'd1, 1'b0);
    bus.blocked_mask = 8'h00;
    bus.inactivate_in_levels = 8'h02;
    tick(1);
    bus.inactivate_in_levels = 8'h00;

    // Service mode flushes hall requests and ignores new hall presses.
    bus.btn_up_out   = 7'h01;
    bus.btn_down_out = 7'h40;
    bus.btn_in       = 8'h10;
    tick(4);
    check_state("svc_pre", 8'h10, 7'h01, 7'h40, 6'd3, 1'b1);
    bus.btn_up_out   = 7'h00;
    bus.btn_down_out = 7'h00;
    bus.btn_in       = 8'h00;
    tick(3);
    bus.service_mode = 1'b1;
    tick(1);
    check_state("svc_flush", 8'h10, 7'h00, 7'h00, 6'd1, 1'b0);
    bus.btn_up_out = 7'h08;
    tick(5);
    check_state("svc_hall_ignored", 8'h10, 7'h00, 7'h00, 6'd1, 1'b0);
    bus.btn_up_out = 7'h00;
    bus.btn_in     = 8'h40;
    tick(4);
    check_state("svc_cabin", 8'h50, 7'h00, 7'h00, 6'd2, 1'b1);
    bus.btn_in = 8'h00;
    tick(3);
    bus.service_mode = 1'b0;
    bus.inactivate_in_levels = 8'hff;
    tick(1);
    bus.inactivate_in_levels = 8'h00;
    check("svc_cleanup_cnt", 32'(bus.pending_count), 32'(0));

    // Every button at once reaches the full count without wrapping.
    bus.btn_in       = 8'hff;
    bus.btn_up_out   = 7'h7f;
    bus.btn_down_out = 7'h7f;
    tick(4);
    check_state("sat", 8'hff, 7'h7f, 7'h7f, 6'd22, 1'b1);
    tick(1);
    check_state("sat_hold", 8'hff, 7'h7f, 7'h7f, 6'd22, 1'b0);
    bus.btn_in       = 8'h00;
    bus.btn_up_out   = 7'h00;
    bus.btn_down_out = 7'h00;
    tick(3);
    bus.inactivate_in_levels = 8'h01;
    tick(1);
    bus.inactivate_in_levels = 8'h00;
    check_state("pre_collide", 8'hfe, 7'h7f, 7'h7f, 6'd21, 1'b0);

    // Qualify and clear on the same edge: clear wins, no pulse.
    bus.btn_in = 8'h01;
    tick(3);
    bus.inactivate_in_levels = 8'h01;
    tick(1);
    check_state("collide", 8'hfe, 7'h7f, 7'h7f, 6'd21, 1'b0);
    bus.inactivate_in_levels = 8'h00;
    tick(1);
    check_state("collide_after", 8'hfe, 7'h7f, 7'h7f, 6'd21, 1'b0);

    // Asynchronous reset mid-operation, released mid-press.
    bus.btn_in = 8'h80;
    #2 reset = 1'b0;
    #1 check_state("async_reset", 8'h00, 7'h00, 7'h00, 6'd0, 1'b0);
    tick(1);
    reset = 1'b1;
    tick(3);
    check("post_reset_early_in", 32'(bus.active_in_levels), 32'(0));
    tick(1);
    check_state("post_reset_set", 8'h80, 7'h00, 7'h00, 6'd1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/call_request_reg.md
# call_request_reg

Parametrised elevator call register: successor to the fixed 8-floor button register. It synchronises and debounces cabin (in) and hall (up/down) buttons for `FLOORS` floors and latches one-shot requests. It also applies a per-floor block mask and a service mode, clears requests on controller command, and reports a registered pending count and a new-request strobe. It sits between the raw button inputs and the elevator control FSM.

## Interface
- `FLOORS`, 8, number of floors (≥2); floor 0 has no down button, floor `FLOORS-1` has no up button.
- `DEBOUNCE`, 2, consecutive synchronised-high cycles required to accept a press (≥1).
- `CNT_W`, `$clog2(3*FLOORS-1)+1`, width of `pending_count` (derived, not overridden).

- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `btn_in` in `[FLOORS-1:0]`: raw cabin buttons, asynchronous.
- `btn_up_out` in `[FLOORS-2:0]`: raw hall-up buttons.
- `btn_down_out` in `[FLOORS-1:1]`: raw hall-down buttons.
- `blocked_mask` in `[FLOORS-1:0]`: 1 = floor blocked; new presses of any button for that floor are dropped.
- `service_mode` in 1: 1 = hall buttons ignored; cabin buttons only.
- `inactivate_in_levels` in `[FLOORS-1:0]`: per-floor clear of cabin requests.
- `inactivate_out_up_levels` in `[FLOORS-2:0]`: per-floor clear of hall-up requests.
- `inactivate_out_down_levels` in `[FLOORS-1:1]`: per-floor clear of hall-down requests.
- `active_in_levels` out `[FLOORS-1:0]`: latched cabin requests.
- `active_out_up_levels` out `[FLOORS-2:0]`: latched hall-up requests.
- `active_out_down_levels` out `[FLOORS-1:1]`: latched hall-down requests.
- `pending_count` out `CNT_W`: number of set bits across all three active vectors.
- `new_request` out 1: one-cycle pulse when at least one request bit newly sets.

## Operation
- **Button channels.** Each channel is one raw button, for `3*FLOORS-2` channels in total. Each channel has the following logic:
  - **Synchroniser.** Two-flop synchroniser producing `s`.
  - **Debounce counter.** Saturating counter, 0..`DEBOUNCE`. It increments while `s`=1 and resets to 0 when `s`=0.
  - **Armed flag.** Set at reset and whenever `s`=0. Cleared when a press qualifies.
- **Qualification.** A press qualifies on the edge where the counter reaches `DEBOUNCE` and the channel is armed. The qualifying press then disarms the channel. A button held indefinitely therefore yields exactly one qualification; it must be released (`s`=0 for ≥1 cycle) before it can qualify again.
- **Latching a request.** A qualified press sets its active bit unless one of the following applies:
  - The floor's `blocked_mask` bit is 1 on that edge.
  - `service_mode`=1 and the channel is a hall channel.
  - The matching inactivate bit is 1 on the same edge. Clear wins.
- A dropped press still disarms the channel.
- **Clearing a request.** The inactivate bit for a channel clears its active bit on the next edge. Clearing an already-clear bit has no effect.
- **Block mask.** Setting a `blocked_mask` bit never clears requests that are already pending.
- **Service mode.** On the first edge where `service_mode`=1 (rising, registered detection), all hall-up and hall-down active bits clear. Cabin bits are unaffected.
- **Pending count.** `pending_count` is registered and equals the popcount of the three active vectors as they are after the same edge. It never lags the outputs.
- **New-request strobe.** `new_request`=1 for the cycle following any edge on which at least one active bit went 0→1. A bit that is already set and qualifies again does not pulse.

## Timing
- **Reset values** (`reset`=0, asynchronous): all active vectors 0, `pending_count`=0, `new_request`=0, synchronisers 0, counters 0, channels armed, service-mode history 0.
- **Press latency.** A raw button that goes high before edge k and is held is first sampled at edge k. The active bit is high after edge k+1+`DEBOUNCE` (default: 3 edges after first sample). `new_request` and `pending_count` update on the same edge.
- **Glitch rejection.** A raw pulse shorter than `DEBOUNCE` synchronised cycles never latches.
- **Clear latency.** Clear sampled at edge k makes the active bit 0 after edge k.
- **Simultaneous qualify and clear.** The bit stays or becomes 0, and there is no `new_request` pulse.
- **Reset released mid-press.** The press is treated as new and requires the full latency.
- **Reset asserted mid-operation.** All state clears immediately, without waiting for a clock.
- **Count range.** The maximum `pending_count` is `3*FLOORS-2` (22 for default). It must not wrap.

## Test plan
- **Reset and single press.** Reset, then press `btn_in[3]` for 5 cycles → `active_in_levels`=0x08 exactly 3 edges after first sample; `new_request` pulses once; `pending_count`=1.
- **Glitch rejection.** 1-cycle pulse on `btn_up_out[2]` → nothing latches; `pending_count` stays 0.
- **Hold and re-arm.** Hold `btn_in[5]`, clear via `inactivate_in_levels[5]` while still held → the bit stays 0. Release, then press again → the bit sets again with one `new_request` pulse.
- **Blocking.** `blocked_mask`=0x04, then press `btn_in[2]` and `btn_down_out[2]` → neither latches. Press `btn_in[1]` → 0x02 latches. Pending bit 1 survives a later `blocked_mask`=0x02.
- **Service mode.** Pending up[0], down[7], in[4] (count 3). Raise `service_mode` → hall bits clear next edge, count=1. Hall presses are ignored while the mode is set.
- **Saturation and collision.** Press all 22 buttons → `pending_count`=22. Qualify `btn_in[0]` on the same edge as `inactivate_in_levels[0]`=1 → bit 0 stays 0 and there is no pulse.
